// File: rtl/mlp_layer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mlp_layer_seq : one fully-connected layer, one MAC per cycle, Q-format    |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module mlp_layer_seq #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int N_IN   = 4,
   parameter int N_OUT  = 4,
   parameter int RELU   = 1,
   localparam int NPAR  = N_OUT * (N_IN + 1),
   localparam int AW    = $clog2(NPAR),
   localparam int NW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [N_IN*DATA_W-1:0]   in_data,
   input  logic                     wt_we,
   input  logic [AW-1:0]            wt_addr,
   input  logic [DATA_W-1:0]        wt_data,
   output logic [DATA_W-1:0]        out,
   output logic                     out_valid,
   output logic [NW-1:0]            out_idx,
   output logic                     busy,
   output logic                     finished
);

   localparam int c_ACC_W = 2 * DATA_W + $clog2(N_IN) + 1;
   localparam int c_SUM_W = c_ACC_W + 1;
   localparam int c_IW    = $clog2(N_IN + 1);
   localparam logic signed [c_SUM_W-1:0] c_SMAX =
      {{(c_SUM_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [c_SUM_W-1:0] c_SMIN =
      {{(c_SUM_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

   state_t                    r_state;
   logic [DATA_W-1:0]         r_mem [NPAR];
   logic [N_IN*DATA_W-1:0]    r_xs;
   logic signed [c_ACC_W-1:0] r_acc;
   logic [c_IW-1:0]           r_i;
   logic [NW-1:0]             r_n;

   logic [AW-1:0]             w_raddr;
   logic signed [DATA_W-1:0]  w_par;
   logic signed [DATA_W-1:0]  w_x;
   logic signed [2*DATA_W-1:0] w_prod;
   logic [N_IN*DATA_W-1:0]    w_rot;
   logic signed [c_SUM_W-1:0] w_bias_sh;
   logic signed [c_SUM_W-1:0] w_sum;
   logic signed [c_SUM_W-1:0] w_shift;
   logic signed [c_SUM_W-1:0] w_act;
   logic [DATA_W-1:0]         w_res;

   // r_i reaches N_IN on the last MAC cycle, so the same address points at the bias in OUT
   assign w_raddr = AW'(int'(r_n) * (N_IN + 1) + int'(r_i));
   assign w_par   = r_mem[w_raddr];
   assign w_x     = r_xs[DATA_W-1:0];
   assign w_prod  = w_x * w_par;

   // Inputs rotate so x_i is always in the low word; N_IN rotations restore the vector
   if (N_IN > 1) begin : g_rot
      assign w_rot = {r_xs[DATA_W-1:0], r_xs[N_IN*DATA_W-1:DATA_W]};
   end else begin : g_norot
      assign w_rot = r_xs;
   end

   assign w_bias_sh = {{(c_SUM_W - DATA_W){w_par[DATA_W-1]}}, w_par} <<< FRAC_W;
   assign w_sum     = {r_acc[c_ACC_W-1], r_acc} + w_bias_sh;
   assign w_shift   = w_sum >>> FRAC_W;

   always_comb begin
      w_act = w_shift;
      if (RELU != 0 && w_shift[c_SUM_W-1]) begin
         w_act = '0;
      end
      if (w_act > c_SMAX) begin
         w_res = c_SMAX[DATA_W-1:0];
      end else if (w_act < c_SMIN) begin
         w_res = c_SMIN[DATA_W-1:0];
      end else begin
         w_res = w_act[DATA_W-1:0];
      end
   end

   // Parameter memory survives reset; busy low is exactly the IDLE/DONE window
   always_ff @(posedge clk) begin
      if (!reset && wt_we && !busy && (int'(wt_addr) < NPAR)) begin
         r_mem[wt_addr] <= wt_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_xs      <= '0;
         r_acc     <= '0;
         r_i       <= '0;
         r_n       <= '0;
         out       <= '0;
         out_idx   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         finished  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_xs     <= in_data;
                  r_acc    <= '0;
                  r_i      <= '0;
                  r_n      <= '0;
                  busy     <= 1'b1;
                  finished <= 1'b0;
                  r_state  <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc <= r_acc + {{(c_ACC_W - 2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
               r_xs  <= w_rot;
               r_i   <= r_i + 1'b1;
               if (r_i == c_IW'(N_IN - 1)) begin
                  r_state <= S_OUT;
               end
            end
            S_OUT: begin
               // Last neuron lingers one extra cycle in OUT so DONE lands one edge after its strobe
               if (out_valid) begin
                  busy     <= 1'b0;
                  finished <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  out       <= w_res;
                  out_idx   <= r_n;
                  out_valid <= 1'b1;
                  r_acc     <= '0;
                  r_i       <= '0;
                  if (r_n != NW'(N_OUT - 1)) begin
                     r_n     <= r_n + 1'b1;
                     r_state <= S_MAC;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mlp_layer_seq : directed bench, RELU=1 and RELU=0 instances side by side|
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_mlp_layer_seq;
   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int N_IN   = 4;
   localparam int N_OUT  = 4;
   localparam int PER    = N_IN + 1;
   localparam int NPAR   = N_OUT * PER;
   localparam int AW     = $clog2(NPAR);
   localparam int NW     = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic wt_we = 1'b0;
   logic [N_IN*DATA_W-1:0] in_data = '0;
   logic [AW-1:0]     wt_addr = '0;
   logic [DATA_W-1:0] wt_data = '0;
   logic [DATA_W-1:0] out1, out0;
   logic              ov1, ov0, busy1, busy0, fin1, fin0;
   logic [NW-1:0]     idx1, idx0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mlp_layer_seq #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_IN(N_IN), .N_OUT(N_OUT), .RELU(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .wt_we(wt_we),
      .wt_addr(wt_addr), .wt_data(wt_data), .out(out1), .out_valid(ov1),
      .out_idx(idx1), .busy(busy1), .finished(fin1));

   mlp_layer_seq #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_IN(N_IN), .N_OUT(N_OUT), .RELU(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data), .wt_we(wt_we),
      .wt_addr(wt_addr), .wt_data(wt_data), .out(out0), .out_valid(ov0),
      .out_idx(idx0), .busy(busy0), .finished(fin0));

   // Reference model: timing from the start edge k, arithmetic in wide integers
   int                cyc = 0;
   bit                active = 1'b0;
   int                k = 0;
   int                m_mem [NPAR];
   int                m_x [N_IN];
   logic [DATA_W-1:0] exp1 [N_OUT];
   logic [DATA_W-1:0] exp0 [N_OUT];
   logic [DATA_W-1:0] h1 = '0, h0 = '0;
   int                hidx = 0;
   logic [DATA_W-1:0] got1 [N_OUT];
   logic [DATA_W-1:0] got0 [N_OUT];
   int                nstrobe = 0;
   bit                chk_en = 1'b0;

   function automatic bit mbusy(int c);
      return active && (c - k) >= 0 && (c - k) <= N_OUT * PER;
   endfunction

   function automatic logic [DATA_W-1:0] neuron(int n, bit relu);
      longint acc;
      longint v;
      acc = 0;
      for (int i = 0; i < N_IN; i++) acc += longint'(m_x[i]) * longint'(m_mem[n*PER+i]);
      v = (acc + longint'(m_mem[n*PER+N_IN]) * (longint'(1) << FRAC_W)) >>> FRAC_W;
      if (relu && v < 0) v = 0;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return v[DATA_W-1:0];
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(posedge clk) begin
      bit was_busy;
      cyc++;
      was_busy = mbusy(cyc - 1);
      if (reset) begin
         active = 1'b0;
         h1 = '0;
         h0 = '0;
         hidx = 0;
      end else begin
         if (wt_we && !was_busy && int'(wt_addr) < NPAR)
            m_mem[int'(wt_addr)] = int'(signed'(wt_data));
         if (start && !was_busy) begin
            active = 1'b1;
            k = cyc;
            nstrobe = 0;
            for (int i = 0; i < N_IN; i++)
               m_x[i] = int'(signed'(in_data[i*DATA_W +: DATA_W]));
            for (int n = 0; n < N_OUT; n++) begin
               exp1[n] = neuron(n, 1'b1);
               exp0[n] = neuron(n, 1'b0);
            end
         end
      end
   end

   always @(negedge clk) begin
      int  d;
      bit  ev;
      if (chk_en) begin
         d  = cyc - k;
         ev = active && d > 0 && (d % PER) == 0 && (d / PER) <= N_OUT;
         if (ev) begin
            h1 = exp1[d/PER-1];
            h0 = exp0[d/PER-1];
            hidx = d / PER - 1;
         end
         chk("valid1", 32'(ov1), 32'(ev));
         chk("valid0", 32'(ov0), 32'(ev));
         chk("busy1", 32'(busy1), 32'(mbusy(cyc)));
         chk("busy0", 32'(busy0), 32'(mbusy(cyc)));
         chk("fin1", 32'(fin1), 32'(active && d > N_OUT * PER));
         chk("fin0", 32'(fin0), 32'(active && d > N_OUT * PER));
         chk("out1", 32'(out1), 32'(h1));
         chk("out0", 32'(out0), 32'(h0));
         chk("idx1", 32'(idx1), 32'(hidx));
         chk("idx0", 32'(idx0), 32'(hidx));
         if (ov1 === 1'b1) begin
            got1[idx1] = out1;
            nstrobe++;
         end
         if (ov0 === 1'b1) got0[idx0] = out0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(int a, logic [DATA_W-1:0] v);
      wt_we = 1'b1;
      wt_addr = AW'(a);
      wt_data = v;
      tick();
      wt_we = 1'b0;
   endtask

   task automatic load(logic [DATA_W-1:0] w, logic [DATA_W-1:0] b);
      for (int n = 0; n < N_OUT; n++) begin
         for (int i = 0; i < N_IN; i++) wr(n*PER+i, w);
         wr(n*PER+N_IN, b);
      end
   endtask

   task automatic setx(logic [DATA_W-1:0] x);
      for (int i = 0; i < N_IN; i++) in_data[i*DATA_W +: DATA_W] = x;
   endtask

   task automatic clear_got();
      for (int n = 0; n < N_OUT; n++) begin
         got1[n] = 'x;
         got0[n] = 'x;
      end
   endtask

   task automatic go();
      clear_got();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (fin1 !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      chk("done_timeout", 32'(fin1), 32'd1);
      tick();
   endtask

   task automatic pin(string nm, logic [DATA_W-1:0] a1, logic [DATA_W-1:0] a0);
      for (int n = 0; n < N_OUT; n++) begin
         chk({nm, "_relu1"}, 32'(got1[n]), 32'(a1));
         chk({nm, "_relu0"}, 32'(got0[n]), 32'(a0));
      end
   endtask

   initial begin
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_out", 32'(out1), 32'h0);
      chk("rst_busy", 32'(busy1), 32'h0);
      chk("rst_fin", 32'(fin1), 32'h0);

      // basic: 4 * (1.0 * 0.5) = 2.0
      load(16'h0080, 16'h0000);
      setx(16'h0100);
      go();
      wait_done();
      pin("basic", 16'h0200, 16'h0200);

      // start plus a write to addr 0 while busy must both be ignored
      go();
      tick();
      tick();
      start = 1'b1;
      wt_we = 1'b1;
      wt_addr = '0;
      wt_data = 16'h0000;
      tick();
      start = 1'b0;
      wt_we = 1'b0;
      wait_done();
      pin("busy_ign", 16'h0200, 16'h0200);

      // reset mid-run after the first strobe, then rerun with retained weights
      go();
      repeat (6) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (3) tick();
      chk("abort_strobes", 32'(nstrobe), 32'd1);
      chk("abort_busy", 32'(busy1), 32'd0);
      chk("abort_fin", 32'(fin0), 32'd0);
      go();
      wait_done();
      pin("rerun", 16'h0200, 16'h0200);

      // negative results; b[2] written in the same cycle as start
      load(16'hFF00, 16'h0000);
      wr(31, 16'h1234);
      clear_got();
      start = 1'b1;
      wt_we = 1'b1;
      wt_addr = AW'(2*PER+N_IN);
      wt_data = 16'h0500;
      tick();
      start = 1'b0;
      wt_we = 1'b0;
      wait_done();
      chk("neg_n0_relu1", 32'(got1[0]), 32'h0000);
      chk("neg_n0_relu0", 32'(got0[0]), 32'hFC00);
      chk("neg_n2_relu1", 32'(got1[2]), 32'h0100);
      chk("neg_n2_relu0", 32'(got0[2]), 32'h0100);
      chk("neg_n3_relu0", 32'(got0[3]), 32'hFC00);

      // saturation both ways
      load(16'h7FFF, 16'h7FFF);
      setx(16'h7FFF);
      go();
      wait_done();
      pin("sat_hi", 16'h7FFF, 16'h7FFF);
      for (int n = 0; n < N_OUT; n++)
         for (int i = 0; i < N_IN; i++) wr(n*PER+i, 16'h8000);
      go();
      wait_done();
      pin("sat_lo", 16'h0000, 16'h8000);

      // -1 LSB product shifts toward -inf
      load(16'h0000, 16'h0000);
      for (int n = 0; n < N_OUT; n++) wr(n*PER, 16'hFFFF);
      setx(16'h0000);
      in_data[DATA_W-1:0] = 16'h0001;
      go();
      wait_done();
      pin("floor", 16'h0000, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mlp_layer_seq.md
MLP_LAYER_SEQ -- requirements
Module: mlp_layer_seq

Interface
REQ-001 Parameters SHALL be declared as follows, one per line: name, default, meaning.
- DATA_W, 16, signed two's-complement width of data, weights, biases and outputs.
- FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W; 1.0 = 0x0100 at defaults).
- N_IN, 4, inputs per neuron.
- N_OUT, 4, neurons in layer.
- RELU, 1, 1 = ReLU activation, 0 = identity.
REQ-002 One clock; reset is synchronous and active-high (ports named clk and reset).
REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request layer evaluation.
- in_data, input, N_IN*DATA_W, flattened input vector; x_i = bits [i*DATA_W +: DATA_W].
- wt_we, input, 1, parameter write strobe.
- wt_addr, input, clog2(N_OUT*(N_IN+1)), parameter index.
- wt_data, input, DATA_W, parameter value.
- out, output, DATA_W, neuron result.
- out_valid, output, 1, one-cycle strobe qualifying out.
- out_idx, output, clog2(N_OUT) (min 1), neuron index of out.
- busy, output, 1, high from start acceptance until finished.
- finished, output, 1, layer complete; level.

Function
REQ-004 Parameter memory SHALL hold N_OUT*(N_IN+1) words at address n*(N_IN+1)+i: i<N_IN is weight w[n][i]; i=N_IN is bias b[n].
REQ-005 Writes SHALL occur only when busy=0; wt_we while busy, or wt_addr >= N_OUT*(N_IN+1), SHALL be ignored.
REQ-006 FSM states SHALL be IDLE, MAC, OUT, DONE; DONE behaves as IDLE for start and writes.
REQ-007 start sampled high at edge k in IDLE/DONE SHALL latch in_data, clear accumulator, set busy=1, clear finished, enter MAC with n=0, i=0.
REQ-008 MAC SHALL add x_i*w[n][i] (full 2*DATA_W product) to a signed accumulator of 2*DATA_W+clog2(N_IN)+1 bits per cycle, for N_IN cycles.
REQ-009 OUT (one cycle) SHALL compute (acc + (b[n] sign-extended << FRAC_W)) arithmetic-shifted right by FRAC_W (truncate toward -inf), apply ReLU if RELU=1, saturate to [0x8000, 0x7FFF] (DATA_W=16), register onto out with out_idx=n and out_valid=1.
REQ-010 Neuron n result SHALL be valid in the cycle after edge k+(n+1)*(N_IN+1); accumulator cleared for n+1 at the same edge.
REQ-011 After neuron N_OUT-1, at edge k+N_OUT*(N_IN+1)+1 the FSM SHALL enter DONE: busy=0, finished=1 held until the next accepted start or reset.
REQ-012 start while busy SHALL be ignored; start and wt_we in the same IDLE cycle SHALL both take effect, with the written value used by that evaluation.
REQ-013 out and out_idx SHALL hold their last value between strobes.

Reset
REQ-014 reset SHALL force IDLE, out=0, out_idx=0, out_valid=0, busy=0, finished=0, accumulator and counters 0, from any state including mid-MAC/OUT.
REQ-015 reset SHALL NOT clear parameter memory; reset has priority over start and wt_we.

Verification
REQ-016 Reset hold 3 cycles -> out=0x0000, out_valid=0, busy=0, finished=0.
REQ-017 All x=0x0100, all w=0x0080, b=0, start at edge k -> out=0x0200 at cycles k+5, k+10, k+15, k+20 with out_idx 0..3; finished=1 from k+21.
REQ-018 x=0x0100, w=0xFF00, b=0 -> RELU=1 gives 0x0000; RELU=0 gives 0xFC00; b[2]=0x0500 with RELU=0 gives 0x0100 for neuron 2.
REQ-019 x=0x7FFF, w=0x7FFF, b=0x7FFF -> out=0x7FFF every neuron; RELU=0, w=0x8000 -> out=0x8000.
REQ-020 reset at k+7 -> only neuron 0 strobe seen, busy=0, finished=0; re-start reproduces REQ-017 results (weights retained).
REQ-021 start and wt_we (addr 0, 0x0000) pulsed at k+3 while busy -> ignored; results match REQ-017.
